uart_rx_frame_parser: RTL and testbench
=======================================

Name: uart_rx_frame_parser

Overview:
- Sits directly downstream of the one-byte UART receiver.
- Consumes its byte/strobe pair (rx_data, rx_done) and assembles framed packets: SOF, LEN, payload, checksum.
- Buffers the payload internally and releases it on a valid/ready byte stream only after the checksum passes.
- Flags malformed, timed-out and overrun frames to the host logic.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, maximum payload bytes (1..255); buffer depth.
- TIMEOUT_CLKS, 50000, max clocks allowed between consecutive bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- rx_data  in  8  byte from UART receiver; valid only when rx_done=1.
- rx_done  in  1  one-cycle strobe, byte available.
- m_data  out  8  payload byte out.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts byte.
- m_last  out  1  high with final payload byte of frame.
- frame_len  out  8  LEN of frame being output; held until next frame enters OUT.
- frame_err  out  1  one-cycle error pulse.
- err_code  out  3  cause of last error; held until next error.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at clk edge) forces the following; any in-progress frame is discarded:
  - state=IDLE
  - m_valid=0, m_last=0, m_data=0, frame_len=0
  - frame_err=0, err_code=0, busy=0
  - all counters and checksum accumulator cleared
- Frame format: SOF, LEN, LEN payload bytes, CHK.
  - CHK = (LEN + sum of payload) mod 256, using 8-bit wrap-around arithmetic.
- States and transitions:
  - IDLE: on rx_done with rx_data==SOF_BYTE -> LEN. Other bytes are ignored silently.
  - LEN: on rx_done:
    - If rx_data==0 or >MAX_LEN: frame_err pulse, err_code=1, -> IDLE.
    - Else latch length, acc=rx_data, wr_ptr=0, -> PAYLOAD.
  - PAYLOAD: on rx_done, buf[wr_ptr]=rx_data, acc+=rx_data, wr_ptr++. After the LEN-th byte -> CHK.
  - CHK: on rx_done:
    - If rx_data==acc: frame_len=LEN, rd_ptr=0, -> OUT.
    - Else: frame_err, err_code=2, -> IDLE.
  - OUT: m_valid=1 from the first cycle in OUT (one clock after the CHK strobe).
    - m_data = buf[rd_ptr]; m_last = (rd_ptr==LEN-1).
    - Transfer occurs when m_valid&&m_ready; rd_ptr then advances.
    - After the transfer with m_last -> IDLE; m_valid deasserts the next cycle.
    - m_data, m_last and m_valid stay stable while m_ready=0.
- Timeout (states LEN, PAYLOAD, CHK only):
  - Counter clears on entry and on every rx_done; increments otherwise.
  - On reaching TIMEOUT_CLKS-1: frame_err, err_code=3, -> IDLE.
  - If rx_done arrives in the same cycle the limit is reached, the byte wins and the counter clears.
  - No timeout in IDLE or OUT.
- Overrun: rx_done during OUT drops the byte and pulses frame_err with err_code=4.
  - State, buffer and output stream are unaffected.
  - Any SOF arriving during OUT is lost.
- Error pulses: frame_err is registered and high for exactly one cycle per event.
- Buffer: MAX_LEN x 8 registers. A new frame may begin only after returning to IDLE, so no read/write overlap occurs.

Test Plan:
- Good frame: rx bytes A5 03 11 22 33 69, m_ready=1 -> m_data 11,22,33 on consecutive cycles; m_last only with 33; frame_len=3; no frame_err.
- Bad checksum: A5 03 11 22 33 6A -> frame_err pulse, err_code=2, m_valid never asserts, busy=0 afterward; then A5 01 7F 80 -> single byte 7F with m_last.
- Length errors: A5 00, and A5 11 with MAX_LEN=16 -> err_code=1 each; idle junk bytes 00 FF 5A before A5 produce no error.
- Timeout: A5 02 44, then silence for TIMEOUT_CLKS clocks -> err_code=3 pulse, IDLE. Also a byte arriving exactly on the limit cycle is accepted.
- Backpressure/overrun:
  - Good 4-byte frame with m_ready toggling 1,0,0,1,... -> all bytes delivered in order, each held stable while m_ready=0.
  - rx_done during OUT -> err_code=4; stream still completes intact.
- Reset mid-frame: assert rst_n=0 for one clock after A5 03 11 -> all outputs at reset values; next full good frame parses correctly.

Source files
------------

// File: rtl/uart_rx_frame_parser.sv
// Framed-packet parser behind a byte UART receiver: SOF, LEN, payload, checksum.
// The payload is buffered and released on a valid/ready stream only after the checksum matches.
module uart_rx_frame_parser #(
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic [7:0] frame_len,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       busy
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHK     = 3'd3;
    localparam logic [2:0] ST_OUT     = 3'd4;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    logic [2:0]      state_r, state_nxt_s;
    logic [7:0]      len_r, acc_r, wr_ptr_r, rd_ptr_r, rd_nxt_s;
    logic [TO_W-1:0] to_cnt_r;
    logic [7:0]      buf_r [0:MAX_LEN-1];
    logic            err_s, timed_s, timeout_s, xfer_s, chk_ok_s;
    logic [2:0]      err_code_s;
    logic [7:0]      m_data_r, frame_len_r;
    logic            m_valid_r, m_last_r, frame_err_r, busy_r;
    logic [2:0]      err_code_r;

    assign m_data    = m_data_r;
    assign m_valid   = m_valid_r;
    assign m_last    = m_last_r;
    assign frame_len = frame_len_r;
    assign frame_err = frame_err_r;
    assign err_code  = err_code_r;
    assign busy      = busy_r;

    assign timed_s   = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CHK);
    assign timeout_s = timed_s && !rx_done && (to_cnt_r == TO_LIMIT);
    assign xfer_s    = m_valid_r && m_ready;
    assign rd_nxt_s  = rd_ptr_r + 8'd1;
    assign chk_ok_s  = (state_r == ST_CHK) && rx_done && (rx_data == acc_r);

    // Next-state and error-event decode
    always_comb begin
        state_nxt_s = state_r;
        err_s       = 1'b0;
        err_code_s  = 3'd0;
        case (state_r)
            ST_IDLE: begin
                if (rx_done && (rx_data == SOF_BYTE)) begin
                    state_nxt_s = ST_LEN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LEN, ST_PAYLOAD, ST_CHK: begin
                if (rx_done) begin
                    if (state_r == ST_LEN) begin
                        if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                            err_s       = 1'b1;
                            err_code_s  = 3'd1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_PAYLOAD;
                        end
                    end else if (state_r == ST_PAYLOAD) begin
                        if (wr_ptr_r == (len_r - 8'd1)) begin
                            state_nxt_s = ST_CHK;
                        end else begin
                            state_nxt_s = ST_PAYLOAD;
                        end
                    end else if (chk_ok_s) begin
                        state_nxt_s = ST_OUT;
                    end else begin
                        err_s       = 1'b1;
                        err_code_s  = 3'd2;
                        state_nxt_s = ST_IDLE;
                    end
                end else if (timeout_s) begin
                    err_s       = 1'b1;
                    err_code_s  = 3'd3;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_OUT: begin
                // A byte arriving while draining cannot be stored; it is reported and dropped
                if (rx_done) begin
                    err_s      = 1'b1;
                    err_code_s = 3'd4;
                end else begin
                    err_s      = 1'b0;
                end
                if (xfer_s && m_last_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Payload buffer write; contents are only read after a complete, verified frame
    always_ff @(posedge clk) begin
        if ((state_r == ST_PAYLOAD) && rx_done) begin
            buf_r[wr_ptr_r[IDX_W-1:0]] <= rx_data;
        end
    end

    // Control state, counters, checksum and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            len_r       <= 8'd0;
            acc_r       <= 8'd0;
            wr_ptr_r    <= 8'd0;
            rd_ptr_r    <= 8'd0;
            to_cnt_r    <= '0;
            m_data_r    <= 8'd0;
            m_valid_r   <= 1'b0;
            m_last_r    <= 1'b0;
            frame_len_r <= 8'd0;
            frame_err_r <= 1'b0;
            err_code_r  <= 3'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            frame_err_r <= err_s;
            if (err_s) begin
                err_code_r <= err_code_s;
            end
            if ((state_nxt_s != state_r) || rx_done || !timed_s) begin
                to_cnt_r <= '0;
            end else begin
                to_cnt_r <= to_cnt_r + 1'b1;
            end
            if ((state_r == ST_LEN) && (state_nxt_s == ST_PAYLOAD)) begin
                len_r    <= rx_data;
                acc_r    <= rx_data;
                wr_ptr_r <= 8'd0;
            end
            if ((state_r == ST_PAYLOAD) && rx_done) begin
                acc_r    <= csum_add(acc_r, rx_data);
                wr_ptr_r <= wr_ptr_r + 8'd1;
            end
            if (chk_ok_s) begin
                frame_len_r <= len_r;
                rd_ptr_r    <= 8'd0;
                m_data_r    <= buf_r[0];
                m_last_r    <= (len_r == 8'd1);
                m_valid_r   <= 1'b1;
            end else if ((state_r == ST_OUT) && xfer_s) begin
                if (m_last_r) begin
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                end else begin
                    rd_ptr_r <= rd_nxt_s;
                    m_data_r <= buf_r[rd_nxt_s[IDX_W-1:0]];
                    m_last_r <= (rd_nxt_s == (len_r - 8'd1));
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench: table of frames plus hand-written timeout, backpressure, overrun and reset sequences.
module tb_uart_rx_frame_parser;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rst_n, rx_done, m_ready;
    logic [7:0] rx_data;
    logic [7:0] m_data, frame_len;
    logic       m_valid, m_last, frame_err, busy;
    logic [2:0] err_code;

    int total = 0;
    int bad   = 0;

    logic [8:0] beat_q[$];
    logic [2:0] err_q[$];
    logic       hold_pend = 1'b0;
    logic [8:0] held;

    typedef struct {
        logic [159:0] bytes;   // right-aligned, first byte in the most significant used slot
        int           nb;
        int           off;
        int           nout;
        logic [2:0]   err;
    } vec_t;
    vec_t tbl[8];

    uart_rx_frame_parser #(.SOF_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(T)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .frame_len(frame_len), .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        rx_data = d;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_idle", 32'(busy), 32'd0);
    endtask

    task automatic settle_and_check_queues();
        repeat (3) @(posedge clk);
        #1;
        chk("beats_left", beat_q.size(), 32'd0);
        chk("errs_left", err_q.size(), 32'd0);
    endtask

    // Scoreboard: stream beats, hold stability and error pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend) begin
                chk("hold_stable", {22'd0, m_valid, m_data, m_last}, {22'd0, 1'b1, held});
            end
            if (m_valid && !m_ready) begin
                hold_pend = 1'b1;
                held      = {m_data, m_last};
            end else begin
                hold_pend = 1'b0;
            end
            if (m_valid && m_ready) begin
                chk("beat_expected", 32'(beat_q.size() != 0), 32'd1);
                if (beat_q.size() != 0) begin
                    chk("beat", {23'd0, m_data, m_last}, {23'd0, beat_q.pop_front()});
                end
            end
            if (frame_err) begin
                chk("err_expected", 32'(err_q.size() != 0), 32'd1);
                if (err_q.size() != 0) begin
                    chk("err_code_pulse", 32'(err_code), 32'(err_q.pop_front()));
                end
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        tbl[0] = '{160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}), 6, 2, 3, 3'd0};
        tbl[1] = '{160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A}), 6, 2, 0, 3'd2};
        tbl[2] = '{160'({8'hA5, 8'h01, 8'h7F, 8'h80}), 4, 2, 1, 3'd0};
        tbl[3] = '{160'({8'hA5, 8'h00}), 2, 2, 0, 3'd1};
        tbl[4] = '{160'({8'hA5, 8'h11}), 2, 2, 0, 3'd1};
        tbl[5] = '{160'({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h01, 8'h02, 8'h05}), 8, 5, 2, 3'd0};
        tbl[6] = '{160'({8'hA5, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                         8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h88}), 19, 2, 16, 3'd0};
        tbl[7] = '{160'({8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00}), 5, 2, 2, 3'd0};

        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {m_valid, m_last, m_data, frame_len, frame_err, err_code, busy},
            {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0});
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < tbl[i].nout; j++) begin
                beat_q.push_back({tbl[i].bytes[(tbl[i].nb - 1 - tbl[i].off - j) * 8 +: 8],
                                  (j == tbl[i].nout - 1)});
            end
            if (tbl[i].err != 3'd0) err_q.push_back(tbl[i].err);
            for (int j = 0; j < tbl[i].nb; j++) begin
                send(tbl[i].bytes[(tbl[i].nb - 1 - j) * 8 +: 8], 1);
            end
            wait_idle(100);
            settle_and_check_queues();
            if (tbl[i].nout > 0) begin
                chk("frame_len", 32'(frame_len), 32'(tbl[i].nout));
            end else begin
                chk("err_code", 32'(err_code), 32'(tbl[i].err));
            end
        end

        // Silence inside a frame: error lands exactly T clocks after the last strobe
        err_q.push_back(3'd3);
        send(8'hA5, 1);
        send(8'h02, 1);
        send(8'h44, 0);
        repeat (T - 1) begin
            @(posedge clk); #1;
        end
        chk("to_busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("to_fired", {29'd0, busy, frame_err, err_code == 3'd3}, {29'd0, 1'b0, 1'b1, 1'b1});
        settle_and_check_queues();

        // A byte on the limit cycle is accepted and the frame completes
        beat_q.push_back({8'h44, 1'b0});
        beat_q.push_back({8'h55, 1'b1});
        send(8'hA5, 1);
        send(8'h02, 1);
        send(8'h44, 0);
        repeat (T - 1) begin
            @(posedge clk); #1;
        end
        send(8'h55, 1);
        send(8'h9B, 0);
        wait_idle(50);
        settle_and_check_queues();
        chk("to_edge_len", 32'(frame_len), 32'd2);

        // Backpressure with m_ready pattern 1,0,0,1
        for (int j = 1; j <= 4; j++) beat_q.push_back({8'(j), (j == 4)});
        m_ready = 1'b0;
        send(8'hA5, 1); send(8'h04, 1); send(8'h01, 1); send(8'h02, 1);
        send(8'h03, 1); send(8'h04, 1); send(8'h0E, 0);
        for (int i = 0; i < 100 && busy; i++) begin
            m_ready = ((i % 4) == 0) || ((i % 4) == 3);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        chk("bp_done", 32'(busy), 32'd0);
        settle_and_check_queues();

        // Overrun: a byte (even a SOF) during OUT is dropped and flagged
        beat_q.push_back({8'h0A, 1'b0});
        beat_q.push_back({8'h0B, 1'b1});
        err_q.push_back(3'd4);
        m_ready = 1'b0;
        send(8'hA5, 1); send(8'h02, 1); send(8'h0A, 1); send(8'h0B, 1);
        send(8'h17, 0);
        send(8'hA5, 2);
        chk("ovr_code", 32'(err_code), 32'd4);
        m_ready = 1'b1;
        wait_idle(50);
        settle_and_check_queues();
        chk("ovr_no_new_frame", 32'(busy), 32'd0);

        // Reset mid-frame, then a clean frame
        send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_outputs", {m_valid, m_last, m_data, frame_len, frame_err, err_code, busy},
            {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0});
        rst_n = 1'b1;
        beat_q.push_back({8'h11, 1'b0});
        beat_q.push_back({8'h22, 1'b0});
        beat_q.push_back({8'h33, 1'b1});
        send(8'hA5, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1);
        send(8'h33, 1); send(8'h69, 1);
        wait_idle(50);
        settle_and_check_queues();
        chk("post_rst_len", 32'(frame_len), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
